sid_write_sched: RTL and testbench

//  Register-write scheduler in front of sid_voices. Arbitrates writes from two

---
 rtl/sid_write_sched.sv | 152 +++++++++++++++
 tb/tb_sid_write_sched.sv | 417 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sid_write_sched.sv
// Register-write scheduler for sid_voices: arbitrates two requesters into a small
// FIFO, issues one write strobe per clkEn period and keeps a readback shadow.
module sid_write_sched #(
  parameter int          FIFO_DEPTH = 4,
  parameter logic [4:0]  MAX_ADDR   = 5'h18
) (
  input  logic                          clk,
  input  logic                          iRstN,
  input  logic                          clkEn,
  input  logic                          iReqValid0,
  input  logic [4:0]                    iReqAddr0,
  input  logic [7:0]                    iReqData0,
  output logic                          oReqReady0,
  input  logic                          iReqValid1,
  input  logic [4:0]                    iReqAddr1,
  input  logic [7:0]                    iReqData1,
  output logic                          oReqReady1,
  input  logic                          iFlush,
  output logic                          oWE,
  output logic [4:0]                    oAddr,
  output logic [7:0]                    oData,
  input  logic [4:0]                    iRdAddr,
  output logic [7:0]                    oRdData,
  output logic [$clog2(FIFO_DEPTH):0]   oLevel,
  output logic                          oDrop,
  output logic                          oBusy
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int LW = PW + 1;

  typedef enum logic [1:0] {IDLE, WAIT_EN, STROBE} state_t;
  typedef struct packed {
    logic [4:0] addr;
    logic [7:0] data;
  } wr_t;

  state_t          r_state;
  logic [PW-1:0]   r_wr_ptr;
  logic [PW-1:0]   r_rd_ptr;
  logic [LW-1:0]   r_level;
  logic            r_rr;
  logic            r_drop;
  logic            r_we;
  logic [4:0]      r_addr;
  logic [7:0]      r_data;
  logic [7:0]      r_rd_data;
  wr_t             r_fifo   [FIFO_DEPTH];
  logic [7:0]      r_shadow [32];

  logic  w_full, w_block, w_grant0, w_grant1, w_accept, w_over, w_push, w_pop;
  wr_t   w_req;
  wr_t   w_head;

  // Ready depends only on occupancy, flush, the valids and the round-robin pointer.
  assign w_full   = (r_level == LW'(FIFO_DEPTH));
  assign w_block  = w_full | iFlush;
  assign w_grant0 = ~w_block & iReqValid0 & (~iReqValid1 | ~r_rr);
  assign w_grant1 = ~w_block & iReqValid1 & (~iReqValid0 |  r_rr);
  assign w_accept = w_grant0 | w_grant1;
  assign w_req    = w_grant1 ? wr_t'{addr: iReqAddr1, data: iReqData1}
                             : wr_t'{addr: iReqAddr0, data: iReqData0};
  assign w_over   = (w_req.addr > MAX_ADDR);
  assign w_push   = w_accept & ~w_over;
  assign w_pop    = (r_state == WAIT_EN) & clkEn & ~iFlush & (r_level != '0);
  assign w_head   = r_fifo[r_rd_ptr];

  assign oReqReady0 = w_grant0;
  assign oReqReady1 = w_grant1;

  // NOTE: FIFO storage is not reset; r_level guards every read, so stale entries are never seen.
  always_ff @(posedge clk) begin
    if (w_push) r_fifo[r_wr_ptr] <= w_req;
  end

  always_ff @(posedge clk or negedge iRstN) begin
    if (!iRstN) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
      r_rr     <= 1'b0;
      r_drop   <= 1'b0;
    end else begin
      r_drop <= w_accept & w_over;
      if (iReqValid0 & iReqValid1 & ~w_block) r_rr <= ~r_rr;
      if (iFlush) begin
        r_wr_ptr <= '0;
        r_rd_ptr <= '0;
        r_level  <= '0;
      end else begin
        if (w_push) r_wr_ptr <= r_wr_ptr + PW'(1);
        if (w_pop)  r_rd_ptr <= r_rd_ptr + PW'(1);
        r_level <= r_level + LW'(w_push) - LW'(w_pop);
      end
    end
  end

  always_ff @(posedge clk or negedge iRstN) begin
    if (!iRstN) begin
      r_state <= IDLE;
      r_we    <= 1'b0;
      r_addr  <= '0;
      r_data  <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          r_we <= 1'b0;
          if (r_level != '0 && !iFlush) r_state <= WAIT_EN;
        end
        WAIT_EN: begin
          r_we <= 1'b0;
          if (iFlush) begin
            r_state <= IDLE;
          end else if (w_pop) begin
            r_addr  <= w_head.addr;
            r_data  <= w_head.data;
            r_we    <= 1'b1;
            r_state <= STROBE;
          end
        end
        STROBE: begin
          r_we    <= 1'b0;
          r_state <= (r_level != '0 && !iFlush) ? WAIT_EN : IDLE;
        end
        default: begin
          r_we    <= 1'b0;
          r_state <= IDLE;
        end
      endcase
    end
  end

  // Readback samples the shadow before this edge's write lands, so a same-cycle hit shows the old value.
  always_ff @(posedge clk or negedge iRstN) begin
    if (!iRstN) begin
      for (int i = 0; i < 32; i++) r_shadow[i] <= '0;
      r_rd_data <= '0;
    end else begin
      if (r_we) r_shadow[r_addr] <= r_data;
      r_rd_data <= r_shadow[iRdAddr];
    end
  end

  assign oWE     = r_we;
  assign oAddr   = r_addr;
  assign oData   = r_data;
  assign oRdData = r_rd_data;
  assign oLevel  = r_level;
  assign oDrop   = r_drop;
  assign oBusy   = (r_level != '0) | (r_state == STROBE);

endmodule

// File: tb/tb_sid_write_sched.sv
// Scoreboard bench for sid_write_sched: expected writes are queued as requests are
// accepted and popped when the DUT strobes oWE.
module tb_sid_write_sched;

  typedef struct packed {
    logic [4:0] addr;
    logic [7:0] data;
  } wr_t;

  logic       clk = 1'b0;
  logic       iRstN, clkEn, iFlush;
  logic       iReqValid0, iReqValid1;
  logic [4:0] iReqAddr0, iReqAddr1, iRdAddr;
  logic [7:0] iReqData0, iReqData1;
  logic       oReqReady0, oReqReady1, oWE, oDrop, oBusy;
  logic [4:0] oAddr;
  logic [7:0] oData, oRdData;
  logic [2:0] oLevel;

  int  checks  = 0;
  int  errors  = 0;
  int  strobes = 0;
  int  cyc     = 0;
  int  en_cnt  = 0;
  bit  en_on   = 1'b0;
  logic exp_rr = 1'b0;
  wr_t sb[$];

  sid_write_sched #(.FIFO_DEPTH(4), .MAX_ADDR(5'h18)) dut (
    .clk(clk), .iRstN(iRstN), .clkEn(clkEn),
    .iReqValid0(iReqValid0), .iReqAddr0(iReqAddr0), .iReqData0(iReqData0), .oReqReady0(oReqReady0),
    .iReqValid1(iReqValid1), .iReqAddr1(iReqAddr1), .iReqData1(iReqData1), .oReqReady1(oReqReady1),
    .iFlush(iFlush), .oWE(oWE), .oAddr(oAddr), .oData(oData),
    .iRdAddr(iRdAddr), .oRdData(oRdData), .oLevel(oLevel), .oDrop(oDrop), .oBusy(oBusy)
  );

  always #5 clk = ~clk;

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // clkEn: one clk high every 16 clk while enabled, first pulse 16 clk after enabling.
  initial begin
    clkEn = 1'b0;
    forever begin
      @(negedge clk);
      if (en_on) begin
        en_cnt = (en_cnt == 15) ? 0 : en_cnt + 1;
        clkEn  = (en_cnt == 0);
      end else begin
        en_cnt = 0;
        clkEn  = 1'b0;
      end
    end
  end

  // Scoreboard consumer: every strobe must match the oldest outstanding expected write.
  initial forever begin
    @(negedge clk);
    if (iRstN === 1'b1 && oWE === 1'b1) begin
      strobes++;
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL unexpected_we got addr=%h data=%h, no write expected", oAddr, oData);
      end else begin
        automatic wr_t exp = sb.pop_front();
        if (oAddr !== exp.addr || oData !== exp.data) begin
          errors++;
          $display("FAIL we_order got addr=%h data=%h want addr=%h data=%h",
                   oAddr, oData, exp.addr, exp.data);
        end
      end
    end
  end

  task automatic idle_reqs();
    iReqValid0 = 1'b0;
    iReqValid1 = 1'b0;
  endtask

  task automatic wait_drain(input string name);
    int k;
    for (k = 0; k < 300; k++) begin
      @(negedge clk);
      if (sb.size() == 0 && oBusy === 1'b0) break;
    end
    checks++;
    if (k == 300) begin
      errors++;
      $display("FAIL %s_drain_timeout got pending=%0d busy=%b want pending=0 busy=0", name, sb.size(), oBusy);
    end
  endtask

  task automatic wait_we(input string name, output bit seen);
    seen = 1'b0;
    for (int k = 0; k < 60; k++) begin
      @(negedge clk);
      if (oWE === 1'b1) begin
        seen = 1'b1;
        break;
      end
    end
    checks++;
    if (!seen) begin
      errors++;
      $display("FAIL %s_we_timeout got no oWE want one within 60 clk", name);
    end
  endtask

  task automatic test_reset();
    iRstN = 1'b1; iFlush = 1'b0; iRdAddr = '0;
    iReqAddr0 = '0; iReqData0 = '0; iReqAddr1 = '0; iReqData1 = '0;
    idle_reqs();
    #2 iRstN = 1'b0;
    #1;
    checks++;
    if ({oWE, oAddr, oData, oRdData, oLevel, oDrop, oBusy} !== '0) begin
      errors++;
      $display("FAIL reset_outputs got we=%b addr=%h data=%h rd=%h lvl=%0d drop=%b busy=%b want all 0",
               oWE, oAddr, oData, oRdData, oLevel, oDrop, oBusy);
    end
    checks++;
    if (oReqReady0 !== 1'b0 || oReqReady1 !== 1'b0) begin
      errors++;
      $display("FAIL reset_ready got %b%b want 00", oReqReady0, oReqReady1);
    end
    repeat (2) @(negedge clk);
    iRstN = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_single();
    bit seen;
    iRdAddr = 5'h01;
    en_on = 1'b1;
    @(negedge clk);
    iReqValid0 = 1'b1; iReqAddr0 = 5'h01; iReqData0 = 8'h1C;
    #1;
    checks++;
    if (oReqReady0 !== 1'b1) begin
      errors++;
      $display("FAIL single_ready got %b want 1", oReqReady0);
    end
    sb.push_back('{addr: 5'h01, data: 8'h1C});
    @(negedge clk);
    idle_reqs();
    wait_we("single", seen);
    @(negedge clk);
    checks++;
    if (oRdData !== 8'h00) begin
      errors++;
      $display("FAIL single_rd_old got %h want 00", oRdData);
    end
    @(negedge clk);
    checks++;
    if (oRdData !== 8'h1C) begin
      errors++;
      $display("FAIL single_rd_new got %h want 1c", oRdData);
    end
    repeat (40) @(negedge clk);
    checks++;
    if (strobes != 1) begin
      errors++;
      $display("FAIL single_we_count got %0d want 1", strobes);
    end
  endtask

  task automatic test_contention();
    int t[4];
    int n = 0;
    en_on = 1'b0;
    repeat (2) @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      iReqValid0 = 1'b1; iReqAddr0 = 5'h02; iReqData0 = 8'(8'h10 + i);
      iReqValid1 = 1'b1; iReqAddr1 = 5'h03; iReqData1 = 8'(8'h20 + i);
      #1;
      checks++;
      if (oReqReady0 !== ~exp_rr || oReqReady1 !== exp_rr) begin
        errors++;
        $display("FAIL contention_grant%0d got rdy0=%b rdy1=%b want rdy0=%b rdy1=%b",
                 i, oReqReady0, oReqReady1, ~exp_rr, exp_rr);
      end
      if (exp_rr) sb.push_back('{addr: 5'h03, data: 8'(8'h20 + i)});
      else        sb.push_back('{addr: 5'h02, data: 8'(8'h10 + i)});
      exp_rr = ~exp_rr;
    end
    @(negedge clk);
    idle_reqs();
    en_on = 1'b1;
    for (int k = 0; k < 120 && n < 4; k++) begin
      @(negedge clk);
      if (oWE === 1'b1) begin
        t[n] = cyc;
        n++;
      end
    end
    checks++;
    if (n != 4) begin
      errors++;
      $display("FAIL contention_we_timeout got %0d strobes want 4", n);
    end else begin
      for (int i = 1; i < 4; i++) begin
        checks++;
        if (t[i] - t[i-1] != 16) begin
          errors++;
          $display("FAIL contention_spacing%0d got %0d want 16", i, t[i] - t[i-1]);
        end
      end
    end
    repeat (3) @(negedge clk);
    checks++;
    if (oAddr !== 5'h03 || oData !== 8'h23) begin
      errors++;
      $display("FAIL contention_hold got addr=%h data=%h want addr=03 data=23", oAddr, oData);
    end
  endtask

  task automatic test_full();
    bit seen;
    int lvl = 0;
    en_on = 1'b0;
    repeat (2) @(negedge clk);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      checks++;
      if (oLevel !== 3'(lvl)) begin
        errors++;
        $display("FAIL full_level%0d got %0d want %0d", i, oLevel, lvl);
      end
      iReqValid0 = 1'b1; iReqAddr0 = 5'h04; iReqData0 = 8'(8'h40 + i);
      #1;
      checks++;
      if (oReqReady0 !== (lvl < 4)) begin
        errors++;
        $display("FAIL full_ready%0d got %b want %b", i, oReqReady0, (lvl < 4));
      end
      if (lvl < 4) begin
        sb.push_back('{addr: 5'h04, data: 8'(8'h40 + i)});
        lvl++;
      end
    end
    @(negedge clk);
    iReqValid1 = 1'b1; iReqAddr1 = 5'h05; iReqData1 = 8'hEE;
    #1;
    checks++;
    if (oLevel !== 3'd4 || oReqReady0 !== 1'b0 || oReqReady1 !== 1'b0) begin
      errors++;
      $display("FAIL full_saturate got lvl=%0d rdy0=%b rdy1=%b want lvl=4 rdy0=0 rdy1=0",
               oLevel, oReqReady0, oReqReady1);
    end
    @(negedge clk);
    idle_reqs();
    en_on = 1'b1;
    wait_we("full", seen);
    checks++;
    if (oLevel !== 3'd3) begin
      errors++;
      $display("FAIL full_after_pop got lvl=%0d want 3", oLevel);
    end
    iReqValid0 = 1'b1; iReqAddr0 = 5'h04; iReqData0 = 8'h4F;
    #1;
    checks++;
    if (oReqReady0 !== 1'b1) begin
      errors++;
      $display("FAIL full_ready_return got %b want 1", oReqReady0);
    end
    sb.push_back('{addr: 5'h04, data: 8'h4F});
    @(negedge clk);
    idle_reqs();
    wait_drain("full");
  endtask

  task automatic test_drop();
    int s0 = strobes;
    @(negedge clk);
    iReqValid1 = 1'b1; iReqAddr1 = 5'h1B; iReqData1 = 8'h55;
    #1;
    checks++;
    if (oReqReady1 !== 1'b1) begin
      errors++;
      $display("FAIL drop_ready got %b want 1", oReqReady1);
    end
    @(negedge clk);
    idle_reqs();
    checks++;
    if (oDrop !== 1'b1 || oLevel !== 3'd0) begin
      errors++;
      $display("FAIL drop_pulse got drop=%b lvl=%0d want drop=1 lvl=0", oDrop, oLevel);
    end
    @(negedge clk);
    checks++;
    if (oDrop !== 1'b0) begin
      errors++;
      $display("FAIL drop_width got %b want 0", oDrop);
    end
    iReqValid1 = 1'b1; iReqAddr1 = 5'h18; iReqData1 = 8'h66;
    #1;
    sb.push_back('{addr: 5'h18, data: 8'h66});
    @(negedge clk);
    idle_reqs();
    checks++;
    if (oDrop !== 1'b0 || oLevel !== 3'd1) begin
      errors++;
      $display("FAIL drop_boundary got drop=%b lvl=%0d want drop=0 lvl=1", oDrop, oLevel);
    end
    wait_drain("drop");
    checks++;
    if (strobes != s0 + 1) begin
      errors++;
      $display("FAIL drop_we_count got %0d want %0d", strobes - s0, 1);
    end
  endtask

  task automatic test_flush();
    bit seen;
    int s0;
    en_on = 1'b0;
    iRdAddr = 5'h05;
    repeat (2) @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      iReqValid0 = 1'b1; iReqAddr0 = 5'(5 + i); iReqData0 = 8'(8'h51 + i);
      #1;
      sb.push_back('{addr: 5'(5 + i), data: 8'(8'h51 + i)});
    end
    @(negedge clk);
    idle_reqs();
    en_on = 1'b1;
    wait_we("flush", seen);
    iFlush = 1'b1;
    iReqValid0 = 1'b1; iReqAddr0 = 5'h08; iReqData0 = 8'h99;
    #1;
    checks++;
    if (oReqReady0 !== 1'b0) begin
      errors++;
      $display("FAIL flush_ready got %b want 0", oReqReady0);
    end
    @(negedge clk);
    iFlush = 1'b0;
    idle_reqs();
    checks++;
    if (oLevel !== 3'd0 || oWE !== 1'b0) begin
      errors++;
      $display("FAIL flush_level got lvl=%0d we=%b want lvl=0 we=0", oLevel, oWE);
    end
    #1;
    sb.delete();
    s0 = strobes;
    @(negedge clk);
    checks++;
    if (oRdData !== 8'h51) begin
      errors++;
      $display("FAIL flush_shadow got %h want 51", oRdData);
    end
    repeat (40) @(negedge clk);
    checks++;
    if (strobes != s0 || oBusy !== 1'b0) begin
      errors++;
      $display("FAIL flush_quiet got extra=%0d busy=%b want extra=0 busy=0", strobes - s0, oBusy);
    end
  endtask

  task automatic test_reset_mid();
    int s0;
    en_on = 1'b0;
    iRdAddr = 5'h01;
    repeat (2) @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      iReqValid0 = 1'b1; iReqAddr0 = 5'(9 + i); iReqData0 = 8'(8'hA0 + i);
    end
    @(negedge clk);
    idle_reqs();
    @(posedge clk);
    #3 iRstN = 1'b0;
    #1;
    checks++;
    if ({oWE, oAddr, oData, oRdData, oLevel, oDrop, oBusy} !== '0) begin
      errors++;
      $display("FAIL reset_mid_outputs got we=%b addr=%h data=%h rd=%h lvl=%0d drop=%b busy=%b want all 0",
               oWE, oAddr, oData, oRdData, oLevel, oDrop, oBusy);
    end
    @(negedge clk);
    iRstN = 1'b1;
    en_on = 1'b1;
    s0 = strobes;
    repeat (2) @(negedge clk);
    checks++;
    if (oRdData !== 8'h00) begin
      errors++;
      $display("FAIL reset_mid_shadow got %h want 00", oRdData);
    end
    repeat (40) @(negedge clk);
    checks++;
    if (strobes != s0 || oLevel !== 3'd0) begin
      errors++;
      $display("FAIL reset_mid_quiet got extra=%0d lvl=%0d want extra=0 lvl=0", strobes - s0, oLevel);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_contention();
    test_full();
    test_drop();
    test_flush();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
